// File: rtl/fetch_buffer.sv
// fetch_buffer: in-order instruction queue between ifetch and decode.
// Each entry holds {fault, pc, instr}. Entries are written when ifetch presents
// a valid tuple and the queue is not full. They are presented to decode over a
// valid/ready handshake. A flush empties the queue in one cycle.
// Optional feature macro: FETCH_BUF_BYPASS_EN. When it is defined and the queue
// is empty, an incoming tuple is shown to decode in the same cycle.
module fetch_buffer #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [31:0]            in_instr,
  input  logic [XLEN-1:0]        in_pc,
  input  logic                   in_fault,
  output logic                   stall,
  output logic                   dec_valid,
  output logic [31:0]            dec_instr,
  output logic [XLEN-1:0]        dec_pc,
  output logic                   dec_fault,
  input  logic                   dec_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  // Storage, split per field so each field has its natural width.
  logic [31:0]     instr_mem_r [DEPTH];
  logic [XLEN-1:0] pc_mem_r    [DEPTH];
  logic            fault_mem_r [DEPTH];

  // Pointers carry one extra MSB so that full and empty can be told apart.
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic [AW-1:0] wr_idx_s;
  logic [AW-1:0] rd_idx_s;

  logic empty_s;
  logic full_s;
  logic push_s;
  logic pop_s;

`ifdef FETCH_BUF_BYPASS_EN
  logic bypass_s;
`endif

  // Queue status derived from the pointers.
  always_comb begin
    wr_idx_s = wr_ptr_r[AW-1:0];
    rd_idx_s = rd_ptr_r[AW-1:0];
    empty_s  = (wr_ptr_r == rd_ptr_r);
    full_s   = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) &&
               (wr_ptr_r[AW] != rd_ptr_r[AW]);
  end

`ifdef FETCH_BUF_BYPASS_EN
  // Bypass is used when nothing is queued ahead of the incoming tuple.
  // If decode takes it in the same cycle, the tuple is never written.
  always_comb begin
    bypass_s = empty_s && in_valid && !flush;
    push_s   = in_valid && !full_s && !flush && !(bypass_s && dec_ready);
    pop_s    = !empty_s && dec_ready && !flush;
  end
`else
  // Push and pop qualification. Flush suppresses both.
  always_comb begin
    push_s = in_valid && !full_s && !flush;
    pop_s  = !empty_s && dec_ready && !flush;
  end
`endif

  // Pointer update. Flush returns both pointers to the origin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else if (flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Entry storage. It is cleared on reset so the head reads as zero afterwards.
  // A flush leaves the contents alone, because the pointers already hide them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_r[i] <= 32'h0000_0000;
        pc_mem_r[i]    <= {XLEN{1'b0}};
        fault_mem_r[i] <= 1'b0;
      end
    end else if (push_s) begin
      instr_mem_r[wr_idx_s] <= in_instr;
      pc_mem_r[wr_idx_s]    <= in_pc;
      fault_mem_r[wr_idx_s] <= in_fault;
    end
  end

`ifdef FETCH_BUF_BYPASS_EN
  // Head presentation. The incoming tuple is shown directly while bypassing.
  always_comb begin
    if (bypass_s) begin
      dec_valid = 1'b1;
      dec_instr = in_instr;
      dec_pc    = in_pc;
      dec_fault = in_fault;
    end else begin
      dec_valid = !empty_s;
      dec_instr = instr_mem_r[rd_idx_s];
      dec_pc    = pc_mem_r[rd_idx_s];
      dec_fault = fault_mem_r[rd_idx_s];
    end
  end
`else
  // Head presentation. The head is always read from storage.
  always_comb begin
    dec_valid = !empty_s;
    dec_instr = instr_mem_r[rd_idx_s];
    dec_pc    = pc_mem_r[rd_idx_s];
    dec_fault = fault_mem_r[rd_idx_s];
  end
`endif

  // Occupancy and back-pressure toward ifetch.
  always_comb begin
    count = wr_ptr_r - rd_ptr_r;
    stall = full_s;
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer.
// It keeps a queue model and checks it against the DUT on every falling edge.
// Directed literal checks pin both the DUT and the model.
module tb_fetch_buffer;

  localparam int XLEN  = 64;
  localparam int DEPTH = 4;
`ifdef FETCH_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        flush     = 1'b0;
  logic        in_valid  = 1'b0;
  logic [31:0] in_instr  = 32'h0;
  logic [63:0] in_pc     = 64'h0;
  logic        in_fault  = 1'b0;
  logic        dec_ready = 1'b0;
  logic        stall;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [63:0] dec_pc;
  logic        dec_fault;
  logic [2:0]  count;

  int tests_run    = 0;
  int tests_failed = 0;

  fetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_fault  (in_fault),
    .stall     (stall),
    .dec_valid (dec_valid),
    .dec_instr (dec_instr),
    .dec_pc    (dec_pc),
    .dec_fault (dec_fault),
    .dec_ready (dec_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run = tests_run + 1;
    if (act !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: a plain FIFO queue ----------------
  typedef struct packed {
    logic        fault;
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t mq[$];

  function automatic logic exp_valid();
    return (mq.size() > 0) || (BYP && in_valid && !flush);
  endfunction

  function automatic ent_t exp_head();
    if (mq.size() > 0) return mq[0];
    else return {in_fault, in_pc, in_instr};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else if (mq.size() > 0) begin
      if (in_valid && mq.size() < DEPTH) mq.push_back({in_fault, in_pc, in_instr});
      if (dec_ready) void'(mq.pop_front());
    end else begin
      if (in_valid && !(BYP && dec_ready)) mq.push_back({in_fault, in_pc, in_instr});
    end
  end

  always @(negedge clk) begin
    chk("m_count", 64'(count), 64'(mq.size()));
    chk("m_stall", 64'(stall), 64'(mq.size() == DEPTH));
    chk("m_dec_valid", 64'(dec_valid), 64'(exp_valid()));
    if (dec_valid && exp_valid()) begin
      chk("m_dec_pc", dec_pc, exp_head().pc);
      chk("m_dec_instr", 64'(dec_instr), 64'(exp_head().instr));
      chk("m_dec_fault", 64'(dec_fault), 64'(exp_head().fault));
    end
  end

  // Handshake log used by the streaming test.
  logic        log_en = 1'b0;
  logic [63:0] log_q[$];
  int          max_cnt = 0;

  always @(negedge clk) begin
    if (log_en) begin
      if (dec_valid && dec_ready && !flush) log_q.push_back(dec_pc);
      if (int'(count) > max_cnt) max_cnt <= int'(count);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                       input logic f, input logic rdy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    in_fault  = f;
    dec_ready = rdy;
    flush     = fl;
  endtask

  task automatic idle();
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_dec_valid", 64'(dec_valid), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_dec_instr", 64'(dec_instr), 64'd0);
    chk("rst_dec_pc", dec_pc, 64'd0);
    chk("rst_dec_fault", 64'(dec_fault), 64'd0);

    // Single push with decode not ready.
    drive(1'b1, 64'h8000_0000, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
    step(); idle(); #1;
    chk("push1_valid", 64'(dec_valid), 64'd1);
    chk("push1_pc", dec_pc, 64'h8000_0000);
    chk("push1_instr", 64'(dec_instr), 64'h13);
    chk("push1_count", 64'(count), 64'd1);
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(); idle();

    // Fill to full, then try a fifth push.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h8000_0000 + 64'(4 * i), 32'h0000_0013 + 32'(i), 1'b0, 1'b0, 1'b0);
      step();
    end
    idle(); #1;
    chk("full_count", 64'(count), 64'd4);
    chk("full_stall", 64'(stall), 64'd1);
    drive(1'b1, 64'h8000_0010, 32'h0000_0099, 1'b0, 1'b0, 1'b0);
    step(); idle(); #1;
    chk("full_ignore_count", 64'(count), 64'd4);
    chk("full_ignore_head", dec_pc, 64'h8000_0000);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      #1;
      chk("pop_order_pc", dec_pc, 64'h8000_0000 + 64'(4 * i));
      step();
      if (i == 0) chk("stall_fall", 64'(stall), 64'd0);
    end
    idle(); #1;
    chk("drained_count", 64'(count), 64'd0);
    chk("drained_valid", 64'(dec_valid), 64'd0);

    // Streaming ten tuples with decode always ready.
    max_cnt = 0;
    log_en  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 64'h9000_0000 + 64'(4 * i), 32'h0000_0100 + 32'(i), 1'b0, 1'b1, 1'b0);
      step();
    end
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    repeat (3) step();
    log_en = 1'b0;
    idle();
    chk("stream_len", 64'(log_q.size()), 64'd10);
    for (int i = 0; i < log_q.size(); i++) begin
      chk("stream_pc", log_q[i], 64'h9000_0000 + 64'(4 * i));
    end
    chk("stream_max_count", 64'(max_cnt), BYP ? 64'd0 : 64'd1);

    // Simultaneous push and pop at occupancy two.
    drive(1'b1, 64'hA000_0000, 32'h0000_0201, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 64'hA000_0004, 32'h0000_0202, 1'b0, 1'b0, 1'b0); step();
    idle(); #1;
    chk("pp_pre_count", 64'(count), 64'd2);
    chk("pp_pre_head", dec_pc, 64'hA000_0000);
    drive(1'b1, 64'hA000_0008, 32'h0000_0203, 1'b0, 1'b1, 1'b0); step();
    idle(); #1;
    chk("pp_count", 64'(count), 64'd2);
    chk("pp_head", dec_pc, 64'hA000_0004);

    // Flush at occupancy three with a tuple arriving.
    drive(1'b1, 64'hA000_000C, 32'h0000_0204, 1'b0, 1'b0, 1'b0); step();
    idle(); #1;
    chk("fl_pre_count", 64'(count), 64'd3);
    drive(1'b1, 64'hDEAD_0000, 32'h0000_0BAD, 1'b0, 1'b0, 1'b1); step();
    idle(); #1;
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_valid", 64'(dec_valid), 64'd0);
    chk("fl_stall", 64'(stall), 64'd0);
    step();
    chk("fl_absent", 64'(count), 64'd0);

    // Fault flag passes through unchanged.
    drive(1'b1, 64'h8000_0010, 32'h0000_0073, 1'b1, 1'b0, 1'b0); step();
    idle(); #1;
    chk("fault_flag", 64'(dec_fault), 64'd1);
    chk("fault_pc", dec_pc, 64'h8000_0010);

    // Asynchronous reset between clock edges.
    drive(1'b1, 64'h8000_0014, 32'h0000_0013, 1'b0, 1'b0, 1'b0); step();
    idle(); #1;
    chk("ar_pre_count", 64'(count), 64'd2);
    #1 reset = 1'b1;
    #1;
    chk("ar_count", 64'(count), 64'd0);
    chk("ar_valid", 64'(dec_valid), 64'd0);
    step(); step();
    reset = 1'b0;
    #1;
    chk("ar_release_count", 64'(count), 64'd0);

    // Same-cycle presentation exists only with the bypass compiled in.
    drive(1'b1, 64'hC000_0000, 32'h0000_0033, 1'b0, 1'b1, 1'b0);
    #1;
    chk("byp_same_cycle_valid", 64'(dec_valid), 64'(BYP));
    step(); idle(); #1;
    chk("byp_after_count", 64'(count), BYP ? 64'd0 : 64'd1);
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b1, 1'b0); step();
    idle(); #1;
    chk("final_count", 64'(count), 64'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
